conv55_16_seq_ctrl: RTL and testbench

//  Sequencer for one 5x5x16 convolution engine. Walks an IMG_H x IMG_W x16 feature map

---
 rtl/conv55_16_seq_ctrl.sv | 154 +++++++++++++++
 tb/tb_conv55_16_seq_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/conv55_16_seq_ctrl.sv
// conv55_16_seq_ctrl: read/enable sequencer for one 5x5x16 convolution engine.
// Walks an IMG_H x IMG_W map as (IMG_H-4) five-row bands, one column read per
// cycle, and tags each read that completes a 5-wide window. The tag and the output
// coordinates travel a (1+ENG_LAT)-deep pipe, so each result appears exactly when
// the engine's convValue is valid. It is presented with a valid/ready handshake.
// A stall (out_valid && !out_ready) freezes the whole pipeline. rd_en and conv_en
// are gated combinationally during a stall, so no read or engine step is lost.
// Optional feature: define CONV_CTRL_PERF_CNT_EN to add the stall_cnt port and counter.
module conv55_16_seq_ctrl #(
  parameter int unsigned IMG_W      = 32,
  parameter int unsigned IMG_H      = 32,
  parameter int unsigned ENG_LAT    = 1,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_row,
  output logic [ADDR_WIDTH-1:0] rd_col,
  output logic                  conv_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_row,
  output logic [ADDR_WIDTH-1:0] out_col
`ifdef CONV_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  localparam int unsigned DEPTH = ENG_LAT + 1;
  localparam logic [ADDR_WIDTH-1:0] COL_LAST  = ADDR_WIDTH'(IMG_W - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_LAST  = ADDR_WIDTH'(IMG_H - 5);
  localparam logic [ADDR_WIDTH-1:0] OCOL_LAST = ADDR_WIDTH'(IMG_W - 5);
  localparam logic [ADDR_WIDTH-1:0] FILL      = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state;
  logic                    conv_q;
  logic [DEPTH-1:0]        tag_vld;
  logic [ADDR_WIDTH-1:0]   tag_row [DEPTH];
  logic [ADDR_WIDTH-1:0]   tag_col [DEPTH];
  logic                    stall_c;
  logic                    last_xfer_c;

  // Pipeline freeze and the final-result handshake.
  assign stall_c     = out_valid && !out_ready;
  assign last_xfer_c = out_valid && out_ready &&
                       (out_row == ROW_LAST) && (out_col == OCOL_LAST);

  // Read and engine enables are suppressed in any stalled cycle.
  assign rd_en   = (state == S_RUN) && !stall_c;
  assign conv_en = conv_q && !stall_c;

  // The last stage of the tag pipe is the presented result.
  assign out_valid = tag_vld[DEPTH-1];
  assign out_row   = tag_row[DEPTH-1];
  assign out_col   = tag_col[DEPTH-1];

  // Sequencer FSM, read counters, and the window tag/coordinate pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_row  <= '0;
      rd_col  <= '0;
      conv_q  <= 1'b0;
      tag_vld <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tag_row[i] <= '0;
        tag_col[i] <= '0;
      end
    end else begin
      done <= 1'b0;

      if (!stall_c) begin
        conv_q     <= rd_en;
        tag_vld[0] <= rd_en && (rd_col >= FILL);
        tag_row[0] <= rd_row;
        tag_col[0] <= (rd_col >= FILL) ? (rd_col - FILL) : '0;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          tag_vld[i] <= tag_vld[i-1];
          tag_row[i] <= tag_row[i-1];
          tag_col[i] <= tag_col[i-1];
        end
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_RUN;
            busy   <= 1'b1;
            rd_row <= '0;
            rd_col <= '0;
          end
        end
        S_RUN: begin
          if (!stall_c) begin
            if (rd_col == COL_LAST) begin
              rd_col <= '0;
              if (rd_row == ROW_LAST) begin
                rd_row <= '0;
                state  <= S_DRAIN;
              end else begin
                rd_row <= rd_row + ONE;
              end
            end else begin
              rd_col <= rd_col + ONE;
            end
          end
        end
        S_DRAIN: begin
          if (last_xfer_c) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CONV_CTRL_PERF_CNT_EN
  // Saturating count of stalled cycles, restarted with each accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((state == S_IDLE) && start) begin
      stall_cnt <= '0;
    end else if (stall_c && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv55_16_seq_ctrl.sv
// Bench for conv55_16_seq_ctrl. Three instances: 8x6 with ENG_LAT=1, 5x5 with
// ENG_LAT=1, and 8x6 with ENG_LAT=3. The reference is a virtual-time model. v
// counts the non-stalled cycles since start acceptance. Read k happens at v=k+1,
// and its result is shown at v=k+2+ENG_LAT. done comes at v=N+2+ENG_LAT.
module tb_conv55_16_seq_ctrl;

  localparam int unsigned AW = 10;
  localparam int CW [3] = '{8, 5, 8};
  localparam int CH [3] = '{6, 5, 6};
  localparam int CL [3] = '{1, 1, 3};

  logic          clk = 1'b0;
  logic          rst;
  logic          t_start   [3];
  logic          t_ready   [3];
  logic          t_busy    [3];
  logic          t_done    [3];
  logic          t_rd_en   [3];
  logic          t_conv_en [3];
  logic          t_ov      [3];
  logic [AW-1:0] t_rd_row  [3];
  logic [AW-1:0] t_rd_col  [3];
  logic [AW-1:0] t_orow    [3];
  logic [AW-1:0] t_ocol    [3];
`ifdef CONV_CTRL_PERF_CNT_EN
  logic [31:0]   t_scnt    [3];
`endif

  int checks = 0;
  int errors = 0;
  int cur_d  = 0;
  int cur_c  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    conv55_16_seq_ctrl #(
      .IMG_W     (CW[g]),
      .IMG_H     (CH[g]),
      .ENG_LAT   (CL[g]),
      .ADDR_WIDTH(AW)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (t_start[g]),
      .busy     (t_busy[g]),
      .done     (t_done[g]),
      .rd_en    (t_rd_en[g]),
      .rd_row   (t_rd_row[g]),
      .rd_col   (t_rd_col[g]),
      .conv_en  (t_conv_en[g]),
      .out_valid(t_ov[g]),
      .out_ready(t_ready[g]),
      .out_row  (t_orow[g]),
      .out_col  (t_ocol[g])
`ifdef CONV_CTRL_PERF_CNT_EN
      ,
      .stall_cnt(t_scnt[g])
`endif
    );
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s dut%0d c%0d: observed %0h expected %0h", tag, cur_d, cur_c, o, e);
    end
  endtask

  task automatic check_idle(input int d, input string tag);
    cur_d = d;
    chk({tag, "_busy"},    32'(t_busy[d]),    32'd0);
    chk({tag, "_done"},    32'(t_done[d]),    32'd0);
    chk({tag, "_rd_en"},   32'(t_rd_en[d]),   32'd0);
    chk({tag, "_conv_en"}, 32'(t_conv_en[d]), 32'd0);
    chk({tag, "_ovalid"},  32'(t_ov[d]),      32'd0);
    chk({tag, "_rd_row"},  32'(t_rd_row[d]),  32'd0);
    chk({tag, "_rd_col"},  32'(t_rd_col[d]),  32'd0);
    chk({tag, "_out_row"}, 32'(t_orow[d]),    32'd0);
    chk({tag, "_out_col"}, 32'(t_ocol[d]),    32'd0);
`ifdef CONV_CTRL_PERF_CNT_EN
    chk({tag, "_stall_cnt"}, t_scnt[d], 32'd0);
`endif
  endtask

  // One full pass on instance d. The cycle of start is c=0.
  // rmode: 0 ready always high, 1 ready low for c in [s_from,s_to), 2 random ready.
  // smode: 0 start only at c0, 1 start held high, 2 random start pulses.
  // abort_at >= 0 asserts rst during that cycle and checks the reset state after it.
  task automatic run_pass(input int d, input int rmode, input int s_from, input int s_to,
                          input int smode, input int abort_at);
    int w, h, l, n, dd, v, ko, nst, nacc;
    bit ev, stall, erd, ecv;
    w = CW[d]; h = CH[d]; l = CL[d];
    n = (h - 4) * w;
    dd = n + 2 + l;
    v = 0; nst = 0; nacc = 0;
    cur_d = d;
    for (int c = 0; c <= 4000; c++) begin
      cur_c = c;
      if (c == 4000) begin
        chk("timeout", 32'd1, 32'd0);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        t_start[d] = 1'b0;
        return;
      end
      if (c == 0 || smode == 1) t_start[d] = 1'b1;
      else if (smode == 2)      t_start[d] = 1'($urandom_range(0, 1));
      else                      t_start[d] = 1'b0;
      case (rmode)
        0:       t_ready[d] = 1'b1;
        1:       t_ready[d] = !(c >= s_from && c < s_to);
        default: t_ready[d] = ($urandom_range(0, 3) != 0);
      endcase
      rst = (c == abort_at);
      #1;
      ko    = v - 2 - l;
      ev    = (ko >= 0) && (ko < n) && ((ko % w) >= 4);
      stall = ev && !t_ready[d];
      erd   = (v >= 1) && (v <= n) && !stall;
      ecv   = (v >= 2) && (v <= n + 1) && !stall;
      chk("busy",    32'(t_busy[d]),    32'(v >= 1 && v < dd));
      chk("done",    32'(t_done[d]),    32'(v == dd));
      chk("rd_en",   32'(t_rd_en[d]),   32'(erd));
      chk("conv_en", 32'(t_conv_en[d]), 32'(ecv));
      chk("ovalid",  32'(t_ov[d]),      32'(ev));
      if (v >= 1 && v <= n) begin
        chk("rd_row", 32'(t_rd_row[d]), 32'((v - 1) / w));
        chk("rd_col", 32'(t_rd_col[d]), 32'((v - 1) % w));
      end
      if (ev) begin
        chk("out_row", 32'(t_orow[d]), 32'(ko / w));
        chk("out_col", 32'(t_ocol[d]), 32'((ko % w) - 4));
        if (t_ready[d]) nacc++;
      end
      if (stall) nst++;
      if (v == dd) begin
        chk("accepted", 32'(nacc), 32'((h - 4) * (w - 4)));
`ifdef CONV_CTRL_PERF_CNT_EN
        chk("stall_cnt", t_scnt[d], 32'(nst));
`endif
      end
      if (c == abort_at) begin
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        t_start[d] = 1'b0;
        t_ready[d] = 1'b1;
        #1;
        cur_c = c + 1;
        check_idle(d, "abort");
        return;
      end
      @(posedge clk);
      if (!stall) v++;
      @(negedge clk);
      if (v > dd) begin
        t_start[d] = 1'b0;
        t_ready[d] = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      t_start[i] = 1'b0;
      t_ready[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) check_idle(i, "reset");
    rst = 1'b0;
    @(negedge clk);

    // Basic pass, then a directed stall on the (0,1) result.
    run_pass(0, 0, 0, 0, 0, -1);
    run_pass(0, 1, 8, 12, 0, -1);
    // Reset in the middle of a pass, then a clean pass.
    run_pass(0, 0, 0, 0, 0, 9);
    run_pass(0, 0, 0, 0, 0, -1);
    // start held high across two chained passes, then random start pulses.
    run_pass(0, 2, 0, 0, 1, -1);
    run_pass(0, 2, 0, 0, 1, -1);
    run_pass(0, 0, 0, 0, 2, -1);
    // Minimum 5x5 map.
    run_pass(1, 0, 0, 0, 0, -1);
    run_pass(1, 2, 0, 0, 2, -1);
    // Longer engine latency.
    run_pass(2, 0, 0, 0, 0, -1);
    run_pass(2, 1, 8, 12, 0, -1);
    run_pass(2, 2, 0, 0, 2, -1);
    // Mixed random traffic.
    for (int i = 0; i < 6; i++) run_pass(i % 3, 2, 0, 0, 2, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
